// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: word geometry, the
// bubble instruction, the fetch FSM states and the queue entry layout.
package if_fetch_stage_pkg;

  localparam int WORD_W      = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,  // no request outstanding
    WAIT = 1'b1   // exactly one request outstanding
  } fetch_state_t;

  // One buffered fetch result: the PC+4 of the word and the word itself.
  typedef struct packed {
    logic [WORD_W-1:0] pc4;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  // Sequential instruction address; wraps modulo 2^32 silently.
  function automatic logic [WORD_W-1:0] next_word_addr(input logic [WORD_W-1:0] addr);
    return addr + WORD_W'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Request/acknowledge bus between the fetch stage and instruction memory.
// The fetch stage is the master; memory answers with a one-cycle ack pulse
// carrying the read data in the same cycle.
interface if_fetch_stage_if
  import if_fetch_stage_pkg::*;
  ();

  logic              req;
  logic [WORD_W-1:0] addr;
  logic              ack;
  logic [WORD_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/if_fetch_stage_fetch_queue.sv
// Two-entry FIFO of fetch results. Entry 0 is always the head, so the
// presented instruction comes straight from a flop. Clear wins over push/pop.
module if_fetch_stage_fetch_queue
  import if_fetch_stage_pkg::*;
  (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_data,
    output logic [1:0]   count,
    output fetch_entry_t head
  );

  logic [1:0]   count_q, count_d;
  fetch_entry_t e0_q, e0_d;
  fetch_entry_t e1_q, e1_d;
  logic         pop_ok;
  logic         push_ok;

  // Gate requests so an empty queue never pops and a full one never overflows.
  always_comb begin
    pop_ok  = pop && (count_q != 2'd0);
    push_ok = push && ((count_q != 2'd2) || pop_ok);
  end

  // Next occupancy and entry contents; entries shift toward the head on pop.
  always_comb begin
    count_d = count_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    if (clear) begin
      count_d = 2'd0;
    end else if (pop_ok && push_ok) begin
      if (count_q == 2'd2) begin
        e0_d = e1_q;
        e1_d = push_data;
      end else begin
        e0_d = push_data;
      end
    end else if (pop_ok) begin
      e0_d    = e1_q;
      count_d = count_q - 2'd1;
    end else if (push_ok) begin
      if (count_q == 2'd0) begin
        e0_d = push_data;
      end else begin
        e1_d = push_data;
      end
      count_d = count_q + 2'd1;
    end
  end

  // Occupancy is control state and follows the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry storage is only meaningful when counted, so it carries no reset.
  always_ff @(posedge clk) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

  assign count = count_q;
  assign head  = e0_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID register. Owns the PC, the
// IDLE/WAIT request FSM, the kill flag for in-flight requests made stale by
// a branch, and the space rule that keeps queue plus outstanding request
// at no more than two instructions.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
  #(
    parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [WORD_W-1:0] NOP_INSTR = if_fetch_stage_pkg::NOP_INSTR
  )
  (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                branch_taken,
    input  logic [WORD_W-1:0]   branch_addr,
    if_fetch_stage_if.master    imem,
    output logic [WORD_W-1:0]   pc_out,
    output logic [WORD_W-1:0]   instr_out,
    output logic                fetch_stall
  );

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic              kill_q, kill_d;

  logic [1:0]        count;
  fetch_entry_t      head;
  fetch_entry_t      push_data;
  logic              push;
  logic              pop;
  logic [1:0]        count_next;
  logic              space;

  // Queue traffic this cycle; an ack seen while IDLE is not a real response.
  always_comb begin
    push = imem.ack && (state_q == WAIT) && !kill_q && !branch_taken;
    pop  = (count != 2'd0) && !freeze && !branch_taken;
    push_data.pc4   = next_word_addr(addr_q);
    push_data.instr = imem.rdata;
  end

  // Occupancy after this edge decides whether a new request may go out.
  always_comb begin
    count_next = count;
    if (branch_taken) begin
      count_next = 2'd0;
    end else if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (pop && !push) begin
      count_next = count - 2'd1;
    end
    space = (count_next < 2'd2);
  end

  // Fetch FSM: issue, hold, back-to-back reissue, and branch redirect/kill.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    kill_d  = kill_q;
    unique case (state_q)
      IDLE: begin
        if (branch_taken) begin
          pc_d = branch_addr;
        end else if (space) begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = pc_q;
          pc_d    = next_word_addr(pc_q);
        end
      end
      WAIT: begin
        if (branch_taken) begin
          pc_d = branch_addr;
          if (imem.ack) begin
            state_d = IDLE;
            req_d   = 1'b0;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (imem.ack) begin
          if (!kill_q && space) begin
            addr_d = pc_q;
            pc_d   = next_word_addr(pc_q);
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
            kill_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        kill_d  = 1'b0;
      end
    endcase
  end

  // Control and address registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      kill_q  <= kill_d;
    end
  end

  if_fetch_stage_fetch_queue u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (branch_taken),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .count     (count),
    .head      (head)
  );

  assign imem.req  = req_q;
  assign imem.addr = addr_q;

  // Present the head pair, or a bubble when nothing is buffered.
  always_comb begin
    fetch_stall = (count == 2'd0);
    pc_out      = fetch_stall ? '0 : head.pc4;
    instr_out   = fetch_stall ? NOP_INSTR : head.instr;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a behavioural instruction memory
// whose wait-state count can be changed between steps.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        fetch_stall;

  if_fetch_stage_if imem_bus ();

  if_fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (imem_bus),
    .pc_out       (pc_out),
    .instr_out    (instr_out),
    .fetch_stall  (fetch_stall)
  );

  int errors = 0;
  int checks = 0;
  int mem_wait = 0;
  int wait_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: each word encodes its own word index.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[17:2]};
  endfunction

  // Memory model: acks after mem_wait idle cycles of a visible request.
  always @(negedge clk) begin
    if (rst || (imem_bus.req !== 1'b1)) begin
      imem_bus.ack   = 1'b0;
      imem_bus.rdata = 32'hDEAD_BEEF;
      wait_cnt       = 0;
    end else begin
      if (imem_bus.ack === 1'b1) wait_cnt = 0;
      if (wait_cnt >= mem_wait) begin
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = mem_word(imem_bus.addr);
      end else begin
        imem_bus.ack   = 1'b0;
        imem_bus.rdata = 32'hDEAD_BEEF;
        wait_cnt++;
      end
    end
  end

  // An ack with no request outstanding would be a protocol violation.
  always @(posedge clk) begin
    if (!rst && (imem_bus.ack === 1'b1) && (imem_bus.req !== 1'b1)) begin
      errors++;
      $error("FAIL ack_without_req: observed ack=1 req=%b required req=1", imem_bus.req);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;

    tick();
    tick();
    check("rst_req",   imem_bus.req,  32'h0);
    check("rst_addr",  imem_bus.addr, 32'h0);
    check("rst_pc",    pc_out,        32'h0);
    check("rst_instr", instr_out,     32'h0);
    check("rst_stall", fetch_stall,   32'h1);

    // Zero-wait streaming.
    rst = 1'b0;
    tick();
    check("s1_req",   imem_bus.req,  32'h1);
    check("s1_addr",  imem_bus.addr, 32'h0);
    check("s1_stall", fetch_stall,   32'h1);
    tick();
    check("s2_pc",    pc_out,        32'h4);
    check("s2_instr", instr_out,     32'hC0DE_0000);
    check("s2_stall", fetch_stall,   32'h0);
    check("s2_addr",  imem_bus.addr, 32'h4);
    tick();
    check("s3_pc",    pc_out,        32'h8);
    check("s3_instr", instr_out,     32'hC0DE_0001);
    check("s3_addr",  imem_bus.addr, 32'h8);
    tick();
    check("s4_pc",    pc_out,        32'hC);
    check("s4_instr", instr_out,     32'hC0DE_0002);

    // Freeze for five cycles: head holds, queue fills, requests stop.
    freeze = 1'b1;
    tick();
    check("fz1_pc",   pc_out,        32'hC);
    check("fz1_req",  imem_bus.req,  32'h0);
    repeat (4) tick();
    check("fz5_pc",    pc_out,       32'hC);
    check("fz5_instr", instr_out,    32'hC0DE_0002);
    check("fz5_req",   imem_bus.req, 32'h0);
    check("fz5_stall", fetch_stall,  32'h0);
    freeze = 1'b0;
    tick();
    check("fr1_pc",    pc_out,        32'h10);
    check("fr1_instr", instr_out,     32'hC0DE_0003);
    check("fr1_req",   imem_bus.req,  32'h1);
    check("fr1_addr",  imem_bus.addr, 32'h10);
    tick();
    check("fr2_pc",    pc_out,        32'h14);
    check("fr2_instr", instr_out,     32'hC0DE_0004);

    // Slow memory: address held three cycles, bubbles in between.
    mem_wait = 2;
    tick();
    check("lt1_stall", fetch_stall,   32'h1);
    check("lt1_instr", instr_out,     32'h0);
    check("lt1_pc",    pc_out,        32'h0);
    check("lt1_addr",  imem_bus.addr, 32'h14);
    tick();
    check("lt2_addr",  imem_bus.addr, 32'h14);
    check("lt2_stall", fetch_stall,   32'h1);
    tick();
    check("lt3_pc",    pc_out,        32'h18);
    check("lt3_instr", instr_out,     32'hC0DE_0005);
    check("lt3_addr",  imem_bus.addr, 32'h18);
    tick();
    check("lt4_stall", fetch_stall,   32'h1);
    tick();
    check("lt5_addr",  imem_bus.addr, 32'h18);
    tick();
    check("lt6_pc",    pc_out,        32'h1C);
    check("lt6_instr", instr_out,     32'hC0DE_0006);
    repeat (3) tick();
    check("lt9_addr",  imem_bus.addr, 32'h20);
    check("lt9_pc",    pc_out,        32'h20);

    // Branch while waiting on 0x20: the late ack is killed.
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    tick();
    branch_taken = 1'b0;
    check("br1_stall", fetch_stall,   32'h1);
    check("br1_instr", instr_out,     32'h0);
    check("br1_req",   imem_bus.req,  32'h1);
    check("br1_addr",  imem_bus.addr, 32'h20);
    tick();
    check("br2_stall", fetch_stall,   32'h1);
    tick();
    check("br3_req",   imem_bus.req,  32'h0);
    check("br3_stall", fetch_stall,   32'h1);
    mem_wait = 0;
    tick();
    check("br4_req",   imem_bus.req,  32'h1);
    check("br4_addr",  imem_bus.addr, 32'h100);
    tick();
    check("br5_pc",    pc_out,        32'h104);
    check("br5_instr", instr_out,     32'hC0DE_0040);

    // Branch coinciding with an ack while frozen and fully occupied.
    freeze       = 1'b1;
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    tick();
    branch_taken = 1'b0;
    check("ba1_stall", fetch_stall,   32'h1);
    check("ba1_instr", instr_out,     32'h0);
    check("ba1_req",   imem_bus.req,  32'h0);
    tick();
    check("ba2_req",   imem_bus.req,  32'h1);
    check("ba2_addr",  imem_bus.addr, 32'h200);
    tick();
    check("ba3_pc",    pc_out,        32'h204);
    check("ba3_instr", instr_out,     32'hC0DE_0080);
    freeze = 1'b0;
    tick();
    check("ba4_pc",    pc_out,        32'h208);
    check("ba4_instr", instr_out,     32'hC0DE_0081);
    check("ba4_addr",  imem_bus.addr, 32'h208);

    // Asynchronous reset in the middle of a pending request.
    mem_wait = 3;
    tick();
    check("ar0_req",  imem_bus.req,  32'h1);
    check("ar0_addr", imem_bus.addr, 32'h208);
    #2;
    rst = 1'b1;
    #1;
    check("ar_req",   imem_bus.req,  32'h0);
    check("ar_addr",  imem_bus.addr, 32'h0);
    check("ar_instr", instr_out,     32'h0);
    check("ar_stall", fetch_stall,   32'h1);
    check("ar_pc",    pc_out,        32'h0);
    tick();
    rst      = 1'b0;
    mem_wait = 0;
    tick();
    check("rr1_req",   imem_bus.req,  32'h1);
    check("rr1_addr",  imem_bus.addr, 32'h0);
    tick();
    check("rr2_pc",    pc_out,        32'h4);
    check("rr2_instr", instr_out,     32'hC0DE_0000);

    // Redirect to the top word: PC+4 wraps to zero.
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    check("wr1_req",   imem_bus.req,  32'h0);
    check("wr1_stall", fetch_stall,   32'h1);
    tick();
    check("wr2_addr",  imem_bus.addr, 32'hFFFF_FFFC);
    tick();
    check("wr3_pc",    pc_out,        32'h0);
    check("wr3_instr", instr_out,     32'hC0DE_FFFF);
    check("wr3_stall", fetch_stall,   32'h0);
    check("wr3_addr",  imem_bus.addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It generates the PC and fetches instructions over a req/ack handshake to a variable-latency instruction memory. Fetched words are buffered in a 2-entry queue, and {PC+4, instruction} pairs are presented to the IF stage register. The block honours freeze from the hazard unit and redirects on taken branches from EXE.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0000, word presented when no valid instruction is available (bubble)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
freeze  in  1  hazard stall; the downstream register holds and nothing is consumed
branch_taken  in  1  single-cycle redirect pulse from EXE
branch_addr  in  32  redirect target; valid when branch_taken=1
imem_req  out  1  memory request, registered
imem_addr  out  32  request address, registered, stable while imem_req=1
imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle
imem_rdata  in  32  instruction word
pc_out  out  32  PC+4 of the presented instruction; feeds PC_in of the IF register
instr_out  out  32  presented instruction, or NOP_INSTR; feeds Instruction_in
fetch_stall  out  1  1 when no valid instruction is presented (bubble)

Behaviour:
- Reset values: pc=RESET_PC; state=IDLE; imem_req=0; imem_addr=0; queue count=0; kill=0; pc_out=0; instr_out=NOP_INSTR; fetch_stall=1.
- Queue: 2 entries, each {pc4, instr}. Outputs come from the head.
  - count=0 -> instr_out=NOP_INSTR, pc_out=0, fetch_stall=1.
  - Otherwise instr_out/pc_out = head, fetch_stall=0.
- Pop: at posedge when count>0, freeze=0 and branch_taken=0.
- Push: at posedge when imem_ack=1, kill=0 and branch_taken=0. The pushed entry is {imem_addr+4, imem_rdata}.
- FSM states: IDLE (no request outstanding), WAIT (one request outstanding).
- Space rule: a request may issue only if count_next < 2, where count_next is count after this cycle's push/pop. This rule guarantees the queue never overflows.
- IDLE, space available, no branch: go to WAIT, imem_req<=1, imem_addr<=pc, pc<=pc+4.
- WAIT, imem_ack=0: hold imem_req and imem_addr unchanged. A request is never withdrawn.
- WAIT, imem_ack=1:
  - Space remains and no kill/branch: stay in WAIT and issue the next request at pc (back-to-back). Sustained throughput is 1 instr/cycle with zero-wait memory acking every cycle.
  - Otherwise: go to IDLE, imem_req<=0.
- branch_taken has highest priority:
  - Queue cleared (count<=0) and pc<=branch_addr.
  - In WAIT without ack: kill<=1. When the ack arrives, its data is discarded, kill<=0, and the FSM goes to IDLE. The next request, to branch_addr, issues from IDLE one cycle later.
  - In WAIT with ack in the same cycle: data discarded, go to IDLE; kill stays 0.
  - In IDLE: no request is issued that cycle. The first fetch at branch_addr is issued on the next cycle.
  - Overlap with freeze: branch still redirects. The bubble is visible once freeze drops.
- freeze: blocks pop only. Fetching continues until the queue plus the outstanding request total 2.
- Second branch_taken while kill=1: update pc only; kill stays 1.
- Address arithmetic is 32-bit modulo. pc 32'hFFFF_FFFC wraps to 0 with no flag. pc[1:0] is carried through unchanged and not checked.
- rst asserted mid-transaction: all state returns to reset values immediately. Any late imem_ack arriving while IDLE after reset is ignored.
- imem_ack while IDLE is illegal; the design ignores it and the bench asserts it never happens.

Decomposition:
- Shared pipeline package: NOP_INSTR constant, WORD_W=32, INSTR_BYTES=4, and the fetch FSM state enum {IDLE, WAIT}.
- One natural sub-module, fetch_queue: 2-entry FIFO with push/pop/clear, count, and head outputs. The top level holds the PC, FSM, kill flag and space rule.

Test Plan:
1. Reset release, zero-wait memory (ack the cycle after req), freeze=0 -> imem_addr sequence 0,4,8,...; pc_out/instr_out show 4/mem[0], 8/mem[1], ... Steady state is one instruction per cycle with fetch_stall=0.
2. freeze=1 for 5 cycles mid-stream -> outputs hold the same head; at most 2 entries fill; imem_req drops with no lost or duplicated instruction. Release resumes in order.
3. 3-cycle memory latency -> imem_addr held stable 3 cycles; fetch_stall=1 bubbles present NOP_INSTR and pc_out=0 between instructions.
4. branch_taken to 32'h100 while WAIT for addr 0x20 with ack 2 cycles later -> 0x20 data dropped, queue emptied. The next imem_addr is 0x100 and the first presented pair is 0x104/mem[0x40].
5. branch_taken coinciding with imem_ack and a full queue -> acked data dropped, count=0, next fetch at branch_addr.
6. rst asserted during WAIT -> imem_req=0 and instr_out=NOP_INSTR asynchronously. The first request after release is to RESET_PC.
